// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, default operand width and small op-decoding helpers.
package mult_div_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Even encodings are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Combinational sign correction of the unsigned 2W result.
// Multiply: the whole 2W product is negated when i_neg_lo is set.
// Divide: quotient (lo) and remainder (hi) are negated independently.
module mult_div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   i_hi,
  input  logic [W-1:0]   i_lo,
  input  logic           i_is_div,
  input  logic           i_neg_lo,
  input  logic           i_neg_hi,
  output logic [2*W-1:0] o_result
);

  logic [2*W-1:0] w_full;
  logic [W-1:0]   w_hi_fix;
  logic [W-1:0]   w_lo_fix;

  assign w_full   = {i_hi, i_lo};
  assign w_hi_fix = i_neg_hi ? -i_hi : i_hi;
  assign w_lo_fix = i_neg_lo ? -i_lo : i_lo;

  // Select 2W negation for products, per-half negation for div results.
  always_comb begin
    o_result = w_full;
    if (i_is_div) begin
      o_result = {w_hi_fix, w_lo_fix};
    end else if (i_neg_lo) begin
      o_result = -w_full;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with flush and
// defined divide-by-zero. Optional HI/LO accumulate (MADD/MSUB family)
// is built only when the macro MULT_DIV_ACC_EN is defined.
//
// Handshake: start is sampled only in IDLE (and only when flush is low and
// the op is legal); busy is high whenever the FSM is not IDLE; done is a
// one-cycle pulse in DONE, with hi_out/lo_out holding the result until the
// next completed operation. flush aborts any non-IDLE state without done.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  state_t        r_state;
  logic [2:0]    r_op;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi_out;
  logic [W-1:0]  r_lo_out;
  logic          r_s1;
  logic          r_s2;
  logic          r_dz;
  logic          r_done;
  logic [CW-1:0] r_cnt;

  logic          w_legal;
  logic          w_signed_in;
  logic [W-1:0]  w_abs1;
  logic [W-1:0]  w_abs2;
  logic [W:0]    w_mul_sum;
  logic [W:0]    w_div_trial;
  logic [W-1:0]  w_next_hi;
  logic [W-1:0]  w_next_lo;
  logic [2*W-1:0] w_fixed;
  logic [2*W-1:0] w_final;

`ifdef MULT_DIV_ACC_EN
  logic [W-1:0]  r_acc_hi;
  logic [W-1:0]  r_acc_lo;
  assign w_legal = 1'b1;
`else
  logic          w_unused_acc;
  assign w_legal      = ~op[2];
  assign w_unused_acc = ^{hi_in, lo_in};
`endif

  // Operand magnitudes for signed ops; sign flags are latched separately.
  assign w_signed_in = op_is_signed(op);
  assign w_abs1      = (w_signed_in && operand_1[W-1]) ? -operand_1 : operand_1;
  assign w_abs2      = (w_signed_in && operand_2[W-1]) ? -operand_2 : operand_2;

  // Multiply step: add multiplicand when lsb of multiplier set, shift right.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide step: shift remainder left by one dividend bit, trial subtract.
  assign w_div_trial = {r_hi, r_lo[W-1]} - {1'b0, r_b};

  // Next partial result for one CALC step.
  always_comb begin
    if (op_is_div(r_op)) begin
      w_next_hi = w_div_trial[W] ? {r_hi[W-2:0], r_lo[W-1]} : w_div_trial[W-1:0];
      w_next_lo = {r_lo[W-2:0], ~w_div_trial[W]};
    end else begin
      w_next_hi = w_mul_sum[W:1];
      w_next_lo = {w_mul_sum[0], r_lo[W-1:1]};
    end
  end

  mult_div_sign_fix #(.W(W)) u_sign_fix (
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_is_div (op_is_div(r_op)),
    .i_neg_lo (r_s1 ^ r_s2),
    .i_neg_hi (r_s1),
    .o_result (w_fixed)
  );

  // Final result: divide-by-zero bypass, optional accumulate, else fixed.
  always_comb begin
    w_final = w_fixed;
`ifdef MULT_DIV_ACC_EN
    if (op_is_acc(r_op)) begin
      w_final = op_is_sub(r_op) ? ({r_acc_hi, r_acc_lo} - w_fixed)
                                : ({r_acc_hi, r_acc_lo} + w_fixed);
    end
`endif
    if (r_dz) begin
      w_final = {r_hi, r_lo};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MULT;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_out <= '0;
      r_lo_out <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
`ifdef MULT_DIV_ACC_EN
      r_acc_hi <= '0;
      r_acc_lo <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && !flush && w_legal) begin
            r_op  <= op;
            r_b   <= w_abs2;
            r_s1  <= w_signed_in & operand_1[W-1];
            r_s2  <= w_signed_in & operand_2[W-1];
            r_cnt <= '0;
`ifdef MULT_DIV_ACC_EN
            r_acc_hi <= hi_in;
            r_acc_lo <= lo_in;
`endif
            if (op_is_div(op) && (operand_2 == '0)) begin
              r_hi    <= operand_1;
              r_lo    <= '1;
              r_dz    <= 1'b1;
              r_state <= ST_FIX;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_abs1;
              r_dz    <= 1'b0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_hi  <= w_next_hi;
            r_lo  <= w_next_lo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(W - 1)) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_hi_out <= w_final[2*W-1:W];
            r_lo_out <= w_final[W-1:0];
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign hi_out = r_hi_out;
  assign lo_out = r_lo_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of single operations plus
// hand-written flush, start-while-busy, accumulate and reset sequences.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic [W-1:0] hi_in;
  logic [W-1:0] lo_in;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Clock / reset
  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: pulse start for one cycle, then wait (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hin, input logic [W-1:0] lin, output int lat);
    op = o; operand_1 = a; operand_2 = b; hi_in = hin; lo_in = lin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;

    vecs[0] = '{"multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
    vecs[1] = '{"mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vecs[2] = '{"div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[3] = '{"divu_5by0", OP_DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 2};
    vecs[4] = '{"div_intmin_by_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[5] = '{"divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34};
    vecs[6] = '{"mult_intmin_x2", OP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[7] = '{"div_7by_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34};
    vecs[8] = '{"div_m5by0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 2};
    vecs[9] = '{"multu_shift", OP_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 34};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MULT;
    operand_1 = '0; operand_2 = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven single operations
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, '0, '0, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_hi"}, hi_out, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo_out, vecs[i].exp_lo);
      @(posedge clk); #1;
      check({vecs[i].name, "_busy_after"}, {31'b0, busy}, 32'd0);
      check({vecs[i].name, "_done_after"}, {31'b0, done}, 32'd0);
    end
    prev_hi = vecs[9].exp_hi;
    prev_lo = vecs[9].exp_lo;

    // Flush mid-MULT with start also high: no done, outputs kept
    d0 = done_cnt;
    op = OP_MULT; operand_1 = 32'd6; operand_2 = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    op = OP_MULTU; operand_1 = 32'd5; operand_2 = 32'd5;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy_next", {31'b0, busy}, 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    check("flush_no_done", done_cnt - d0, 32'd0);
    check("flush_stays_idle", {31'b0, busy}, 32'd0);
    check("flush_hi_kept", hi_out, prev_hi);
    check("flush_lo_kept", lo_out, prev_lo);
    run_op(OP_MULTU, 32'd5, 32'd5, '0, '0, lat);
    check("after_flush_latency", lat, 32'd34);
    check("after_flush_hi", hi_out, 32'd0);
    check("after_flush_lo", lo_out, 32'd25);
    @(posedge clk); #1;

    // start pulsed while busy is ignored
    d0 = done_cnt;
    op = OP_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    op = OP_MULTU; operand_1 = 32'd3; operand_2 = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_start_latency", lat, 32'd34);
    repeat (40) begin @(posedge clk); #1; end
    check("busy_start_single_done", done_cnt - d0, 32'd1);
    check("busy_start_hi", hi_out, 32'd2);
    check("busy_start_lo", lo_out, 32'd14);

    // Accumulate ops
`ifdef MULT_DIV_ACC_EN
    run_op(OP_MADD, 32'd3, 32'd4, 32'd0, 32'd10, lat);
    check("madd_latency", lat, 32'd34);
    check("madd_hi", hi_out, 32'd0);
    check("madd_lo", lo_out, 32'd22);
    @(posedge clk); #1;
    run_op(OP_MSUB, 32'd3, 32'd4, 32'd0, 32'd10, lat);
    check("msub_latency", lat, 32'd34);
    check("msub_hi", hi_out, 32'hFFFFFFFF);
    check("msub_lo", lo_out, 32'hFFFFFFFE);
    @(posedge clk); #1;
`else
    d0 = done_cnt;
    op = OP_MADD; operand_1 = 32'd3; operand_2 = 32'd4; hi_in = 32'd0; lo_in = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("madd_illegal_busy", {31'b0, busy}, 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    check("madd_illegal_no_done", done_cnt - d0, 32'd0);
    check("madd_illegal_hi_kept", hi_out, 32'd2);
    check("madd_illegal_lo_kept", lo_out, 32'd14);
`endif

    // Asynchronous reset in the middle of an operation
    op = OP_MULTU; operand_1 = 32'hFFFFFFFF; operand_2 = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midop_reset_busy", {31'b0, busy}, 32'd0);
    check("midop_reset_done", {31'b0, done}, 32'd0);
    check("midop_reset_hi", hi_out, 32'd0);
    check("midop_reset_lo", lo_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(OP_DIVU, 32'd9, 32'd0, '0, '0, lat);
    check("post_reset_dz_latency", lat, 32'd2);
    check("post_reset_dz_hi", hi_out, 32'd9);
    check("post_reset_dz_lo", lo_out, 32'hFFFFFFFF);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit that serves the EX stage over a start/done handshake. It replaces the fixed 32-bit, single-shot mult/div path and adds:
- signed and unsigned radix-2 multiply and restoring divide;
- flush/cancel;
- defined divide-by-zero behaviour;
- optional HI/LO accumulate.

Its result is written to HI/LO by EX when `done` is asserted.

## Interface
- `DATA_WIDTH`, default 32: operand width W; result is 2W (hi:lo).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `operand_1` input W: multiplicand / dividend (rs).
- `operand_2` input W: multiplier / divisor (rt).
- `hi_in` input W: current HI, for accumulate ops.
- `lo_in` input W: current LO, for accumulate ops.
- `flush` input 1: cancel the in-flight operation.
- `busy` output 1: operation in progress (not IDLE).
- `done` output 1: one-cycle pulse; result valid.
- `hi_out` output W: product high half / remainder.
- `lo_out` output W: product low half / quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start` with a legal op latches `op`, `operand_1`, `operand_2`, `hi_in` and `lo_in`.
  - Signed ops latch absolute values plus the result sign flags.
  - Step counter is cleared; go to CALC.
- CALC: one shift-add (mult) or restore-subtract (div) step per cycle; after W steps, go to FIX.
- FIX:
  - Apply sign correction: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - For MADD/MSUB: add/subtract the 2W product to/from the latched {hi_in, lo_in}, modulo 2^(2W).
  - Go to DONE.
- DONE:
  - `done`=1 for this one cycle; `hi_out`/`lo_out` registered.
  - Return to IDLE.
  - Outputs hold until the next completed operation.
- Divide by zero (DIV/DIVU with `operand_2`=0):
  - Skip CALC; IDLE→FIX→DONE.
  - `lo_out` = all-ones, `hi_out` = `operand_1`.
- Signed overflow, DIV of INT_MIN by −1: `lo_out` = INT_MIN, `hi_out` = 0 (natural wrap; no trap).
- `start` while `busy`=1 is ignored.
- `flush`:
  - In any non-IDLE state, return to IDLE on the next edge.
  - No `done`; `hi_out`/`lo_out` keep their previous values.
- `flush` and `start` in the same cycle: flush wins, start is ignored.
- Reset, including mid-operation: state IDLE, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, counter 0.

## Timing
- `start` is sampled at edge E0.
- Normal ops:
  - `busy`=1 from E0 until the edge that leaves DONE.
  - `done` is high in the cycle after edge E0+W+1 (CALC W cycles, FIX 1, DONE 1).
  - Total latency is W+2 cycles (34 for W=32).
- Divide by zero: `done` in the cycle after E0+1 (latency 2).
- Back-to-back: a new `start` can be accepted on the edge that leaves DONE+1 (IDLE); minimum issue interval is W+3 cycles.
- `busy` deasserts in the cycle after DONE; `done` is never high while in IDLE.

## Configuration
- `MULT_DIV_ACC_EN` defined:
  - ops 4–7 are legal.
  - `hi_in`/`lo_in` are latched and used in FIX.
- Not defined:
  - ops 4–7 are illegal; `start` with them is ignored (stay in IDLE, no `done`).
  - `hi_in`/`lo_in` are unused; the accumulate adder is not built.
  - Ports remain present.

## Structure
- Shared package `mult_div_pkg`:
  - op encoding constants (OP_MULT … OP_MSUBU);
  - state enum;
  - default `DATA_WIDTH`.
- One sub-module, `mult_div_sign_fix`: combinational negation/sign correction of the 2W result, parametrised by W.
- Counter width is $clog2(W+1).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_out`=0xFFFFFFFE, `lo_out`=0x00000001; `done` exactly 34 cycles after `start`.
- MULT −3 × 7 → `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB. DIV −7 / 2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF.
- DIVU 5 / 0 → `lo_out`=0xFFFFFFFF, `hi_out`=0x00000005; `done` 2 cycles after `start`. DIV 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- MULT in flight, `flush` at cycle 10 (with `start` also high) → no `done`, `busy`=0 next cycle, outputs unchanged; following `start` is accepted normally.
- `start` pulsed again while `busy` → ignored; single `done`, result of the first operation only.
- MADD 3 × 4 with {`hi_in`,`lo_in`}={0,10} → `lo_out`=22, `hi_out`=0 with `MULT_DIV_ACC_EN`; without it → `busy` stays 0 and no `done`.
